// File: rtl/fft2d_frame_feeder.sv
// fft2d_frame_feeder
// Holds one complex ROWS x N frame and streams it to the 2D FFT as
// LANES-wide beats. Row mode emits ROWS transforms of length N. Column
// mode emits N transforms of length ROWS by reading the buffer transposed.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   wr_en_i, wr_row_i,      frame buffer write port (accepted in IDLE only)
//   wr_col_i, wr_re_i,
//   wr_im_i
//   start_i, col_mode_i     frame start pulse and mode (sampled together)
//   abort_i                 cancel the frame in progress
//   ready_i                 downstream accepts the presented beat
//   valid_o, sop_o          beat valid, first beat of a transform
//   dr_o, di_o              packed lanes, lane 0 in the MSB slot
//   busy_o, done_o          frame in progress, end-of-frame pulse
//   state_o                 FSM state for debug (0 = IDLE, 1 = RUN)
//
// Handshake: a beat transfers on any clock edge where valid_o && ready_i.
// Once valid_o is high, the beat (valid_o, sop_o, dr_o, di_o) holds
// stable until it transfers; abort_i or rst_i are the only ways to
// withdraw it.
module fft2d_frame_feeder #(
  parameter int NB    = 12,
  parameter int N     = 32,
  parameter int ROWS  = 32,
  parameter int LANES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [$clog2(ROWS)-1:0] wr_row_i,
  input  logic [$clog2(N)-1:0]    wr_col_i,
  input  logic [NB-1:0]           wr_re_i,
  input  logic [NB-1:0]           wr_im_i,
  input  logic                    start_i,
  input  logic                    col_mode_i,
  input  logic                    abort_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic                    sop_o,
  output logic [LANES*NB-1:0]     dr_o,
  output logic [LANES*NB-1:0]     di_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    state_o
);

  localparam int RW    = $clog2(ROWS);
  localparam int CB    = $clog2(N);
  localparam int AW    = RW + CB;
  localparam int TW    = (RW > CB) ? RW : CB;
  localparam int S_ROW = N / LANES;
  localparam int S_COL = ROWS / LANES;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  if ((N & (N - 1)) != 0 || (ROWS & (ROWS - 1)) != 0 || (LANES & (LANES - 1)) != 0 ||
      N < 2 || ROWS < 2 || LANES < 1 || (N % LANES) != 0 || (ROWS % LANES) != 0)
  begin : g_param_check
    $error("fft2d_frame_feeder: N, ROWS, LANES must be powers of two with LANES dividing N and ROWS");
  end

  logic [NB-1:0]        r_re_mem [ROWS*N];
  logic [NB-1:0]        r_im_mem [ROWS*N];

  logic                 r_state;
  logic                 r_mode;
  logic                 r_all;      // every beat of the frame has been loaded
  logic [TW-1:0]        r_t;        // transform index of the next beat to load
  logic [TW-1:0]        r_cnt;      // beat-in-transform index of the next beat
  logic                 r_valid;
  logic                 r_sop;
  logic                 r_done;
  logic [LANES*NB-1:0]  r_dr;
  logic [LANES*NB-1:0]  r_di;

  logic                 w_mode;
  logic [TW-1:0]        w_t;
  logic [TW-1:0]        w_cnt;
  logic [TW-1:0]        w_last_cnt;
  logic                 w_last;
  logic                 w_take;
  logic [TW-1:0]        w_e;
  logic [AW-1:0]        w_addr;
  logic [LANES*NB-1:0]  w_dr;
  logic [LANES*NB-1:0]  w_di;

  // In IDLE the beat being built is beat 0 of a frame in the mode on
  // col_mode_i, so a start can load it on the same edge (beat 0 visible
  // the cycle after start).
  always_comb begin
    w_mode     = (r_state == ST_IDLE) ? col_mode_i : r_mode;
    w_t        = (r_state == ST_IDLE) ? '0 : r_t;
    w_cnt      = (r_state == ST_IDLE) ? '0 : r_cnt;
    w_last_cnt = w_mode ? TW'(S_COL - 1) : TW'(S_ROW - 1);
    w_last     = (w_cnt == w_last_cnt) &&
                 (w_t == (w_mode ? TW'(N - 1) : TW'(ROWS - 1)));
    w_take     = !r_valid || ready_i;
    w_dr       = '0;
    w_di       = '0;
    w_e        = '0;
    w_addr     = '0;
    for (int k = 0; k < LANES; k++) begin
      w_e    = w_cnt + TW'(k * (w_mode ? S_COL : S_ROW));
      // Buffer is row-major: address = row * N + col.
      w_addr = w_mode ? {w_e[RW-1:0], w_t[CB-1:0]} : {w_t[RW-1:0], w_e[CB-1:0]};
      w_dr[(LANES-1-k)*NB +: NB] = r_re_mem[w_addr];
      w_di[(LANES-1-k)*NB +: NB] = r_im_mem[w_addr];
    end
  end

  // Buffer is not reset; writes only land while no frame is streaming.
  always_ff @(posedge clk_i) begin
    if (r_state == ST_IDLE && wr_en_i) begin
      r_re_mem[{wr_row_i, wr_col_i}] <= wr_re_i;
      r_im_mem[{wr_row_i, wr_col_i}] <= wr_im_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_mode  <= 1'b0;
      r_all   <= 1'b0;
      r_t     <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_done  <= 1'b0;
      r_dr    <= '0;
      r_di    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE || (!abort_i && w_take && !r_all)) begin
        // Load the next beat: either beat 0 on start, or the following
        // beat once the output register is free.
        if (r_state == ST_RUN || start_i) begin
          r_state <= ST_RUN;
          if (r_state == ST_IDLE) r_mode <= col_mode_i;
          r_valid <= 1'b1;
          r_sop   <= (w_cnt == '0);
          r_dr    <= w_dr;
          r_di    <= w_di;
          r_all   <= w_last;
          if (w_cnt == w_last_cnt) begin
            r_cnt <= '0;
            r_t   <= w_t + 1'b1;
          end else begin
            r_cnt <= w_cnt + 1'b1;
            r_t   <= w_t;
          end
        end
      end else if (abort_i) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
        r_sop   <= 1'b0;
        r_all   <= 1'b0;
        r_t     <= '0;
        r_cnt   <= '0;
      end else if (w_take) begin
        // All beats loaded and the output register frees up: if it held
        // the last beat, that beat just transferred and the frame ends.
        r_valid <= 1'b0;
        r_sop   <= 1'b0;
        if (r_valid) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
          r_all   <= 1'b0;
          r_t     <= '0;
          r_cnt   <= '0;
        end
      end
    end
  end

  assign valid_o = r_valid;
  assign sop_o   = r_sop;
  assign dr_o    = r_dr;
  assign di_o    = r_di;
  assign busy_o  = (r_state == ST_RUN);
  assign done_o  = r_done;
  assign state_o = r_state;

endmodule

// File: tb/tb_fft2d_frame_feeder.sv
module tb_fft2d_frame_feeder;

  localparam int NB    = 12;
  localparam int N     = 32;
  localparam int ROWS  = 32;
  localparam int LANES = 4;
  localparam int W     = 2 * LANES * NB;
  localparam int HW    = LANES * NB;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_i = 1'b1;
  logic              wr_en_i = 1'b0;
  logic [4:0]        wr_row_i = '0;
  logic [4:0]        wr_col_i = '0;
  logic [NB-1:0]     wr_re_i = '0;
  logic [NB-1:0]     wr_im_i = '0;
  logic              start_i = 1'b0;
  logic              col_mode_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              ready_i = 1'b0;
  logic              valid_o;
  logic              sop_o;
  logic [HW-1:0]     dr_o;
  logic [HW-1:0]     di_o;
  logic              busy_o;
  logic              done_o;
  logic              state_o;

  fft2d_frame_feeder #(.NB(NB), .N(N), .ROWS(ROWS), .LANES(LANES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_row_i(wr_row_i),
    .wr_col_i(wr_col_i), .wr_re_i(wr_re_i), .wr_im_i(wr_im_i),
    .start_i(start_i), .col_mode_i(col_mode_i), .abort_i(abort_i),
    .ready_i(ready_i), .valid_o(valid_o), .sop_o(sop_o), .dr_o(dr_o),
    .di_o(di_o), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [NB-1:0] x_re [ROWS][N];
  logic [NB-1:0] x_im [ROWS][N];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Beat b of a frame: transform t = b / S, position c = b % S, lane k
  // carries element c + k*S; lane 0 is the leftmost field.
  function automatic logic [W-1:0] model_beat(input logic mode, input int b);
    int s, t, c, e;
    logic [HW-1:0] r, i;
    s = (mode ? ROWS : N) / LANES;
    t = b / s;
    c = b % s;
    r = '0;
    i = '0;
    for (int k = 0; k < LANES; k++) begin
      e = c + k * s;
      r[(LANES-1-k)*NB +: NB] = mode ? x_re[e][t] : x_re[t][e];
      i[(LANES-1-k)*NB +: NB] = mode ? x_im[e][t] : x_im[t][e];
    end
    return {r, i};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write(input int r, input int c, input logic [NB-1:0] re, input logic [NB-1:0] im);
    wr_en_i  = 1'b1;
    wr_row_i = 5'(r);
    wr_col_i = 5'(c);
    wr_re_i  = re;
    wr_im_i  = im;
    step();
    wr_en_i  = 1'b0;
    x_re[r][c] = re;
    x_im[r][c] = im;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, W'(valid_o), W'(0));
    chk({tag, "_sop"},   W'(sop_o),   W'(0));
    chk({tag, "_dr"},    W'(dr_o),    W'(0));
    chk({tag, "_di"},    W'(di_o),    W'(0));
    chk({tag, "_busy"},  W'(busy_o),  W'(0));
    chk({tag, "_done"},  W'(done_o),  W'(0));
    chk({tag, "_state"}, W'(state_o), W'(0));
  endtask

  // Streams one frame. rdy_mode: 0 ready high, 1 random, 2 three-cycle
  // stall while beat 5 is presented. kill_kind: 1 abort, 2 reset, at
  // transferred-beat count kill_at. inject_at: issue start+write mid-run.
  // cyc returns the cycle (1 = cycle after start) in which done_o is seen.
  task automatic run_frame(input logic mode, input int rdy_mode, input int kill_kind,
                           input int kill_at, input int inject_at, output int cyc);
    int s, nbeats, n, stall;
    bit done_seen, injected, stalled;
    s = (mode ? ROWS : N) / LANES;
    nbeats = (mode ? N : ROWS) * s;
    exp_q.delete();
    got_q.delete();
    for (int b = 0; b < nbeats; b++) exp_q.push_back(model_beat(mode, b));
    col_mode_i = mode;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    col_mode_i = ~mode;
    chk("start_valid", W'(valid_o), W'(1));
    chk("start_busy",  W'(busy_o),  W'(1));
    n = 0; cyc = 1; done_seen = 0; injected = 0; stall = 0; stalled = 0;
    while (!done_seen && cyc < 3000) begin
      if (kill_kind != 0 && n == kill_at) begin
        if (kill_kind == 1) begin
          abort_i = 1'b1;
          ready_i = 1'b1;
          step();
          abort_i = 1'b0;
          chk("abort_valid", W'(valid_o), W'(0));
          chk("abort_busy",  W'(busy_o),  W'(0));
          chk("abort_state", W'(state_o), W'(0));
          for (int j = 0; j < 20; j++) begin
            if (done_o) done_seen = 1;
            step();
          end
          chk("abort_no_done", W'(done_seen), W'(0));
        end else begin
          ready_i = 1'b0;
          rst_i = 1'b1;
          step();
          rst_i = 1'b0;
          check_all_zero("midrst");
        end
        cyc = -1;
        return;
      end
      case (rdy_mode)
        0: ready_i = 1'b1;
        1: ready_i = ($urandom_range(0, 3) != 0);
        default: begin
          if (n == 5 && !stalled) begin stall = 3; stalled = 1; end
          ready_i = (stall == 0);
          if (stall > 0) stall--;
        end
      endcase
      if (valid_o) begin
        if (exp_q.size() == 0) chk("extra_beat", W'(1), W'(0));
        else begin
          chk("beat_data", {dr_o, di_o}, exp_q[0]);
          chk("beat_sop", W'(sop_o), W'((n % s) == 0));
          if (ready_i) begin
            got_q.push_back({dr_o, di_o});
            void'(exp_q.pop_front());
            n++;
          end
        end
      end
      if (inject_at >= 0 && n == inject_at && !injected) begin
        injected = 1;
        start_i = 1'b1;
        wr_en_i = 1'b1;
        wr_row_i = '0;
        wr_col_i = '0;
        wr_re_i = 12'hFFF;
        wr_im_i = 12'hFFF;
      end
      step();
      start_i = 1'b0;
      wr_en_i = 1'b0;
      cyc++;
      if (done_o) done_seen = 1;
    end
    chk("frame_done_seen", W'(done_seen), W'(1));
    chk("frame_beats", W'(n), W'(nbeats));
    chk("end_valid", W'(valid_o), W'(0));
    chk("end_busy",  W'(busy_o),  W'(0));
    chk("end_state", W'(state_o), W'(0));
  endtask

  // Spec-literal beats of the row-mode frame over the index preload.
  task automatic check_row_literals(input string tag);
    chk({tag, "_b0"}, W'(got_q[0][W-1:HW]), W'(48'h000_008_010_018));
    chk({tag, "_b7"}, W'(got_q[7][W-1:HW]), W'(48'h007_00F_017_01F));
    chk({tag, "_b8"}, W'(got_q[8][W-1:HW]), W'(48'h020_028_030_038));
    chk({tag, "_b8_im"}, W'(got_q[8][HW-1:0]), W'(48'h820_828_830_838));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    repeat (3) step();
    check_all_zero("reset");
    rst_i = 1'b0;
    step();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < N; c++)
        write(r, c, NB'(r * 32 + c), NB'(12'h800 | (r * 32 + c)));

    // Row mode, ready high; column frame starts in the done cycle.
    run_frame(1'b0, 0, 0, 0, -1, cyc);
    chk("row_done_cycle", W'(cyc), W'(257));
    check_row_literals("row");
    chk("b2b_done_pulse", W'(done_o), W'(1));
    run_frame(1'b1, 0, 0, 0, -1, cyc);
    chk("col_done_cycle", W'(cyc), W'(257));
    chk("col_b0", W'(got_q[0][W-1:HW]), W'(48'h000_100_200_300));
    chk("col_b1", W'(got_q[1][W-1:HW]), W'(48'h020_120_220_320));
    chk("col_b8", W'(got_q[8][W-1:HW]), W'(48'h001_101_201_301));

    // Backpressure on beat 5.
    step();
    run_frame(1'b0, 2, 0, 0, -1, cyc);
    chk("bp_done_cycle", W'(cyc), W'(260));
    chk("bp_b5", W'(got_q[5][W-1:HW]), W'(48'h005_00D_015_01D));

    // start/write during RUN are ignored; model keeps 000 at (0,0).
    step();
    run_frame(1'b0, 0, 0, 0, 20, cyc);
    chk("inject_done_cycle", W'(cyc), W'(257));
    run_frame(1'b0, 0, 0, 0, -1, cyc);
    chk("repeat_lane0", W'(got_q[0][W-1:W-NB]), W'(12'h000));

    // Same write in IDLE is visible in the next frame.
    write(0, 0, 12'hFFF, 12'hFFF);
    run_frame(1'b0, 0, 0, 0, -1, cyc);
    chk("idle_write_lane0", W'(got_q[0][W-1:W-NB]), W'(12'hFFF));
    write(0, 0, 12'h000, 12'h800);

    // Abort at beat 100, then restart.
    run_frame(1'b0, 0, 1, 100, -1, cyc);
    run_frame(1'b0, 0, 0, 0, -1, cyc);
    chk("restart_done_cycle", W'(cyc), W'(257));
    chk("restart_b0", W'(got_q[0][W-1:HW]), W'(48'h000_008_010_018));

    // Reset at beat 50 with ready low; buffer survives.
    step();
    run_frame(1'b0, 0, 2, 50, -1, cyc);
    run_frame(1'b0, 0, 0, 0, -1, cyc);
    chk("postrst_done_cycle", W'(cyc), W'(257));
    check_row_literals("postrst");

    // Random contents, random ready, both modes.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < N; c++)
        write(r, c, NB'($urandom), NB'($urandom));
    run_frame(1'b0, 1, 0, 0, -1, cyc);
    step();
    run_frame(1'b1, 1, 0, 0, -1, cyc);
    step();
    run_frame(1'b1, 1, 1, $urandom_range(1, 200), -1, cyc);
    run_frame(1'b1, 0, 0, 0, -1, cyc);
    chk("rand_col_done_cycle", W'(cyc), W'(257));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
